// File: rtl/thermtrip_pkg.sv
// Shared constants for the thermal-trip shutdown sequencer: state encoding,
// source bit positions and default timer lengths (2 MHz clock ticks).
package thermtrip_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    MONITOR  = 3'd2,
    QUAL     = 3'd3,
    LOG      = 3'd4,
    SHUTDOWN = 3'd5,
    LATCHED  = 3'd6
  } state_e;

  localparam int SRC_CPU1 = 0;
  localparam int SRC_CPU2 = 1;
  localparam int SRC_MEM1 = 2;
  localparam int SRC_MEM2 = 3;
  localparam int SRC_W    = 4;

  localparam int T_ARM_DEF  = 20;    // 10 us
  localparam int T_QUAL_DEF = 200;   // 100 us
  localparam int T_BMC_DEF  = 2000;  // 1 ms

  // Largest of the three timer limits; sizes the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/thermtrip_seq_if.sv
// BMC / power-sequencer handshake bundle of the thermal-trip sequencer.
// master = the sequencer side, slave = the BMC / power-sequencer side.
interface thermtrip_seq_if;
  import thermtrip_pkg::*;

  logic             iBmcAck;
  logic             iPwrDownDone;
  logic             iClrLatch;
  logic             oBmcAlert_n;
  logic             FM_THERMTRIP_DLY;
  logic             oThermLatched;
  logic [SRC_W-1:0] oThermSrc;
  logic [2:0]       oState;

  modport master (
    input  iBmcAck, iPwrDownDone, iClrLatch,
    output oBmcAlert_n, FM_THERMTRIP_DLY, oThermLatched, oThermSrc, oState
  );

  modport slave (
    output iBmcAck, iPwrDownDone, iClrLatch,
    input  oBmcAlert_n, FM_THERMTRIP_DLY, oThermLatched, oThermSrc, oState
  );
endinterface

// File: rtl/thermtrip_seq_gencntr.sv
// Generic saturating up-counter with synchronous clear; used as the
// sequencer's single shared state timer.
module genCntr #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEn,
  input  logic             iClr,
  output logic [WIDTH-1:0] oCnt
);

  logic [WIDTH-1:0] cnt_q;

  // Clear wins over count; hold at all-ones instead of wrapping.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q <= '0;
    end else if (iClr) begin
      cnt_q <= '0;
    end else if (iEn && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign oCnt = cnt_q;

endmodule

// File: rtl/thermtrip_seq.sv
// Thermal-trip shutdown sequencer: qualifies CPU/memory thermal pins,
// alerts the BMC, requests power-down and keeps a source-coded record.
module thermtrip_seq
  import thermtrip_pkg::*;
#(
  parameter int T_ARM_2M  = T_ARM_DEF,
  parameter int T_QUAL_2M = T_QUAL_DEF,
  parameter int T_BMC_2M  = T_BMC_DEF
) (
  input  logic iClk_2M,
  input  logic iRst_n,
  input  logic iCpuPwrgdDly,
  input  logic FM_CPU1_THERMTRIP_LVT3_N,
  input  logic FM_CPU2_THERMTRIP_LVT3_N,
  input  logic FM_MEM_THERM_EVENT_CPU1_LVT3_N,
  input  logic FM_MEM_THERM_EVENT_CPU2_LVT3_N,
  input  logic FM_CPU2_SKTOCC_LVT3_N,
  thermtrip_seq_if.master bus
);

  localparam int T_MAX = max3(T_ARM_2M, T_QUAL_2M, T_BMC_2M);
  localparam int TW    = $clog2(T_MAX + 1);

  // Pin order: {sktocc, mem2, mem1, cpu2, cpu1}, all active-low.
  logic [4:0]       pin_raw;
  logic [4:0]       sync1_q, sync2_q;
  logic [SRC_W-1:0] evt;
  logic             any_evt;
  state_e           state_q, state_d;
  logic [SRC_W-1:0] cap_q, cap_d;
  logic             alert_n_q, alert_n_d;
  logic             trip_q, trip_d;
  logic             latched_q, latched_d;
  logic             tmr_en, tmr_clr;
  logic [TW-1:0]    tmr;
  logic             arm_done, qual_done, bmc_done;

  assign pin_raw = {FM_CPU2_SKTOCC_LVT3_N, FM_MEM_THERM_EVENT_CPU2_LVT3_N,
                    FM_MEM_THERM_EVENT_CPU1_LVT3_N, FM_CPU2_THERMTRIP_LVT3_N,
                    FM_CPU1_THERMTRIP_LVT3_N};

  // Two-flop synchronizers; reset to the inactive (high) pin level.
  always_ff @(posedge iClk_2M or negedge iRst_n) begin
    if (!iRst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= pin_raw;
      sync2_q <= sync1_q;
    end
  end

  // Masked event vector: CPU2 sources only count with CPU2 installed.
  always_comb begin
    evt           = '0;
    evt[SRC_CPU1] = ~sync2_q[0];
    evt[SRC_CPU2] = ~sync2_q[1] & ~sync2_q[4];
    evt[SRC_MEM1] = ~sync2_q[2];
    evt[SRC_MEM2] = ~sync2_q[3] & ~sync2_q[4];
  end

  assign any_evt = |evt;

  assign arm_done  = (tmr == TW'(T_ARM_2M - 1));
  assign qual_done = (tmr == TW'(T_QUAL_2M - 1));
  assign bmc_done  = (tmr == TW'(T_BMC_2M - 1));

  genCntr #(.WIDTH(TW)) u_timer (
    .iClk   (iClk_2M),
    .iRst_n (iRst_n),
    .iEn    (tmr_en),
    .iClr   (tmr_clr),
    .oCnt   (tmr)
  );

  // Next-state, capture register and output decode.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    tmr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cap_d = '0;
        if (iCpuPwrgdDly) state_d = ARM;
      end
      ARM: begin
        tmr_en = 1'b1;
        if (!iCpuPwrgdDly)  state_d = IDLE;
        else if (arm_done)  state_d = MONITOR;
      end
      MONITOR: begin
        if (!iCpuPwrgdDly) state_d = IDLE;
        else if (any_evt)  state_d = QUAL;
      end
      QUAL: begin
        tmr_en = 1'b1;
        if (!iCpuPwrgdDly) begin
          state_d = IDLE;
          cap_d   = '0;
        end else if (!any_evt) begin
          // Event vanished: drop what was gathered so glitches never add up.
          state_d = MONITOR;
          cap_d   = '0;
        end else begin
          cap_d = cap_q | evt;
          if (qual_done) state_d = LOG;
        end
      end
      LOG: begin
        tmr_en = 1'b1;
        // Already qualified, so losing power still leaves a record.
        if (!iCpuPwrgdDly)                state_d = LATCHED;
        else if (bus.iBmcAck || bmc_done) state_d = SHUTDOWN;
      end
      SHUTDOWN: begin
        if (bus.iPwrDownDone) state_d = LATCHED;
      end
      LATCHED: begin
        if (bus.iClrLatch && !iCpuPwrgdDly) begin
          state_d = IDLE;
          cap_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cap_d   = '0;
      end
    endcase
    tmr_clr   = (state_d != state_q);
    alert_n_d = ~((state_d == LOG) || (state_d == SHUTDOWN) || (state_d == LATCHED));
    trip_d    = (state_d == SHUTDOWN);
    latched_d = (state_d == LATCHED);
  end

  // State, capture and output registers; reset forces outputs inactive at once.
  always_ff @(posedge iClk_2M or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      cap_q     <= '0;
      alert_n_q <= 1'b1;
      trip_q    <= 1'b0;
      latched_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      alert_n_q <= alert_n_d;
      trip_q    <= trip_d;
      latched_q <= latched_d;
    end
  end

  assign bus.oBmcAlert_n      = alert_n_q;
  assign bus.FM_THERMTRIP_DLY = trip_q;
  assign bus.oThermLatched    = latched_q;
  assign bus.oThermSrc        = cap_q;
  assign bus.oState           = state_q;

endmodule

// File: tb/tb_thermtrip_seq.sv
// Bench for thermtrip_seq: directed step table, hand-written reset case and
// a randomized run compared against a cycle-count reference model.
module tb_thermtrip_seq;
  import thermtrip_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwrgd = 1'b0;
  logic [4:0] pins = 5'h1f;   // {sktocc, mem2, mem1, cpu2, cpu1}
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  thermtrip_seq_if bus();

  thermtrip_seq dut (
    .iClk_2M                        (clk),
    .iRst_n                         (rst_n),
    .iCpuPwrgdDly                   (pwrgd),
    .FM_CPU1_THERMTRIP_LVT3_N       (pins[0]),
    .FM_CPU2_THERMTRIP_LVT3_N       (pins[1]),
    .FM_MEM_THERM_EVENT_CPU1_LVT3_N (pins[2]),
    .FM_MEM_THERM_EVENT_CPU2_LVT3_N (pins[3]),
    .FM_CPU2_SKTOCC_LVT3_N          (pins[4]),
    .bus                            (bus)
  );

  // Packed observation: {state[2:0], alert_n, trip, latched, src[3:0]}
  function automatic logic [9:0] dut_obs();
    return {bus.oState, bus.oBmcAlert_n, bus.FM_THERMTRIP_DLY,
            bus.oThermLatched, bus.oThermSrc};
  endfunction

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got st=%0d al_n=%0b trip=%0b lat=%0b src=%h  exp st=%0d al_n=%0b trip=%0b lat=%0b src=%h",
               name, got[9:7], got[6], got[5], got[4], got[3:0],
               exp[9:7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase numbers follow the published state encoding; age = cycles spent
  // in the current phase, used for the arm/qualify/BMC windows.
  int         m_p, m_age;
  logic [3:0] m_src;
  logic [4:0] m_s1, m_s2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p = 0; m_age = 0; m_src = 4'h0; m_s1 = 5'h1f; m_s2 = 5'h1f;
    end else begin
      logic [3:0] ev;
      int np;
      ev[0] = ~m_s2[0];
      ev[1] = ~m_s2[1] & ~m_s2[4];
      ev[2] = ~m_s2[2];
      ev[3] = ~m_s2[3] & ~m_s2[4];
      np = m_p;
      case (m_p)
        0: if (pwrgd) np = 1;
        1: if (!pwrgd) np = 0; else if (m_age + 1 == T_ARM_DEF) np = 2;
        2: if (!pwrgd) np = 0; else if (ev != 0) np = 3;
        3: if (!pwrgd) begin np = 0; m_src = 0; end
           else if (ev == 0) begin np = 2; m_src = 0; end
           else begin
             m_src = m_src | ev;
             if (m_age + 1 == T_QUAL_DEF) np = 4;
           end
        4: if (!pwrgd) np = 6; else if (bus.iBmcAck || (m_age + 1 == T_BMC_DEF)) np = 5;
        5: if (bus.iPwrDownDone) np = 6;
        6: if (bus.iClrLatch && !pwrgd) begin np = 0; m_src = 0; end
        default: np = 0;
      endcase
      m_age = (np == m_p) ? m_age + 1 : 0;
      m_p   = np;
      m_s2  = m_s1;
      m_s1  = pins;
    end
  end

  function automatic logic [9:0] model_obs();
    return {3'(m_p), ~(m_p >= 4), (m_p == 5), (m_p == 6), m_src};
  endfunction

  // ---------------- directed step table ----------------
  typedef struct {
    logic       pg;
    logic [4:0] p;
    logic       ack, done, clr;
    int         cyc;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic pg, input logic [4:0] p, input logic a, input logic d,
                     input logic c, input int n, input logic [2:0] st, input logic al,
                     input logic tr, input logic la, input logic [3:0] sr);
    vec_t v;
    v.pg = pg; v.p = p; v.ack = a; v.done = d; v.clr = c; v.cyc = n;
    v.exp = {st, al, tr, la, sr};
    tbl.push_back(v);
  endtask

  initial begin
    bus.iBmcAck = 0; bus.iPwrDownDone = 0; bus.iClrLatch = 0;

    // IDLE
    add(0, 5'h1f, 0, 0, 0, 3,    3'd0, 1, 0, 0, 4'h0);
    // CPU1 trip, ack 50 cycles into LOG
    add(1, 5'h1f, 0, 0, 0, 1,    3'd1, 1, 0, 0, 4'h0);
    add(1, 5'h1f, 0, 0, 0, 19,   3'd1, 1, 0, 0, 4'h0);
    add(1, 5'h1f, 0, 0, 0, 1,    3'd2, 1, 0, 0, 4'h0);
    add(1, 5'h1e, 0, 0, 0, 2,    3'd2, 1, 0, 0, 4'h0);
    add(1, 5'h1e, 0, 0, 0, 1,    3'd3, 1, 0, 0, 4'h0);
    add(1, 5'h1e, 0, 0, 0, 199,  3'd3, 1, 0, 0, 4'h1);
    add(1, 5'h1e, 0, 0, 0, 1,    3'd4, 0, 0, 0, 4'h1);  // alert at 203
    add(1, 5'h1e, 0, 0, 0, 49,   3'd4, 0, 0, 0, 4'h1);
    add(1, 5'h1e, 1, 0, 0, 1,    3'd5, 0, 1, 0, 4'h1);
    add(1, 5'h1f, 0, 0, 0, 5,    3'd5, 0, 1, 0, 4'h1);
    add(1, 5'h1f, 0, 1, 0, 1,    3'd6, 0, 0, 1, 4'h1);
    add(1, 5'h1f, 0, 0, 1, 3,    3'd6, 0, 0, 1, 4'h1);  // clear ignored, pwrgd=1
    add(0, 5'h1f, 0, 0, 0, 2,    3'd6, 0, 0, 1, 4'h1);
    add(0, 5'h1f, 0, 0, 1, 1,    3'd0, 1, 0, 0, 4'h0);
    add(0, 5'h1f, 0, 0, 0, 1,    3'd0, 1, 0, 0, 4'h0);
    // CPU2 sources masked when socket empty
    add(1, 5'h1f, 0, 0, 0, 21,   3'd2, 1, 0, 0, 4'h0);
    add(1, 5'h1d, 0, 0, 0, 300,  3'd2, 1, 0, 0, 4'h0);
    add(1, 5'h17, 0, 0, 0, 10,   3'd2, 1, 0, 0, 4'h0);
    // Mem1 episodes too short: QUAL aborted twice
    add(1, 5'h1b, 0, 0, 0, 150,  3'd3, 1, 0, 0, 4'h4);
    add(1, 5'h1f, 0, 0, 0, 3,    3'd2, 1, 0, 0, 4'h0);
    add(1, 5'h1b, 0, 0, 0, 150,  3'd3, 1, 0, 0, 4'h4);
    add(1, 5'h1f, 0, 0, 0, 3,    3'd2, 1, 0, 0, 4'h0);
    // Mem2 with CPU2 present, BMC timeout
    add(1, 5'h07, 0, 0, 0, 203,  3'd4, 0, 0, 0, 4'h8);
    add(1, 5'h07, 0, 0, 0, 1999, 3'd4, 0, 0, 0, 4'h8);
    add(1, 5'h07, 0, 0, 0, 1,    3'd5, 0, 1, 0, 4'h8);
    add(1, 5'h07, 0, 1, 0, 1,    3'd6, 0, 0, 1, 4'h8);
    add(0, 5'h1f, 0, 0, 1, 1,    3'd0, 1, 0, 0, 4'h0);
    // Pwrgd lost during LOG goes straight to LATCHED
    add(1, 5'h1f, 0, 0, 0, 21,   3'd2, 1, 0, 0, 4'h0);
    add(1, 5'h1e, 0, 0, 0, 203,  3'd4, 0, 0, 0, 4'h1);
    add(0, 5'h1e, 0, 0, 0, 1,    3'd6, 0, 0, 1, 4'h1);
    add(0, 5'h1f, 0, 0, 1, 1,    3'd0, 1, 0, 0, 4'h0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", dut_obs(), {3'd0, 1'b1, 1'b0, 1'b0, 4'h0});
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      pwrgd = tbl[i].pg; pins = tbl[i].p;
      bus.iBmcAck = tbl[i].ack; bus.iPwrDownDone = tbl[i].done; bus.iClrLatch = tbl[i].clr;
      repeat (tbl[i].cyc) @(posedge clk);
      @(negedge clk);
      $display("vec %0d: pg=%0b pins=%h ack=%0b done=%0b clr=%0b cyc=%0d -> st=%0d",
               i, tbl[i].pg, tbl[i].p, tbl[i].ack, tbl[i].done, tbl[i].clr,
               tbl[i].cyc, bus.oState);
      chk($sformatf("vec%0d", i), dut_obs(), tbl[i].exp);
    end

    // Asynchronous reset in the middle of SHUTDOWN
    bus.iClrLatch = 0; pwrgd = 1; pins = 5'h1f;
    repeat (21) @(posedge clk);
    @(negedge clk); pins = 5'h1e;
    repeat (203) @(posedge clk);
    @(negedge clk); bus.iBmcAck = 1;
    @(posedge clk);
    @(negedge clk); bus.iBmcAck = 0;
    chk("pre_rst_shutdown", dut_obs(), {3'd5, 1'b0, 1'b1, 1'b0, 4'h1});
    #1 rst_n = 1'b0;
    #1 chk("async_rst", dut_obs(), {3'd0, 1'b1, 1'b0, 1'b0, 4'h0});
    $display("reset mid-SHUTDOWN: st=%0d trip=%0b al_n=%0b", bus.oState,
             bus.FM_THERMTRIP_DLY, bus.oBmcAlert_n);
    @(negedge clk);
    rst_n = 1'b1; pins = 5'h1f; pwrgd = 0;

    // Randomized segments against the reference model
    for (int s = 0; s < 110; s++) begin
      int len, ack_rate, errs_before;
      len = $urandom_range(1, 450);
      ack_rate = ($urandom_range(0, 2) == 0) ? 0 : 40;
      pins = ($urandom_range(0, 9) < 4) ? 5'h1f : 5'($urandom);
      pwrgd = ($urandom_range(0, 7) != 0);
      errs_before = errors;
      for (int c = 0; c < len; c++) begin
        bus.iBmcAck      = (ack_rate != 0) && ($urandom_range(0, ack_rate - 1) == 0);
        bus.iPwrDownDone = ($urandom_range(0, 29) == 0);
        bus.iClrLatch    = ($urandom_range(0, 19) == 0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("rand%0d_c%0d", s, c), dut_obs(), model_obs());
      end
      $display("seg %0d: len=%0d pins=%h pg=%0b end st=%0d new_errors=%0d",
               s, len, pins, pwrgd, bus.oState, errors - errs_before);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thermtrip_seq.md
# thermtrip_seq

Thermal-trip shutdown sequencer for the Wilson City core CPLD. It qualifies CPU thermtrip and memory thermal events, masking CPU2 sources when CPU2 is absent. It gives the BMC a bounded window to log the event, then requests a platform power-down. It holds a latched, source-coded record until the BMC clears it while CPU power is off. It sits between the LVT3 thermal pins and the master power sequencer's shutdown input.

## Interface

Parameters:
- T_ARM_2M, 20: cycles of stable iCpuPwrgdDly before monitoring starts (10 us).
- T_QUAL_2M, 200: cycles a masked event must persist before it is qualified (100 us).
- T_BMC_2M, 2000: maximum cycles to wait for BMC acknowledge (1 ms).

Ports:
- iClk_2M  in  1  2 MHz clock.
- iRst_n  in  1  Reset; asynchronous, active-low.
- iCpuPwrgdDly  in  1  Delayed CPU power-good; high means the thermal pins are valid.
- FM_CPU1_THERMTRIP_LVT3_N  in  1  CPU1 thermtrip, active-low, asynchronous.
- FM_CPU2_THERMTRIP_LVT3_N  in  1  CPU2 thermtrip, active-low, asynchronous.
- FM_MEM_THERM_EVENT_CPU1_LVT3_N  in  1  CPU1 memory thermal event, active-low.
- FM_MEM_THERM_EVENT_CPU2_LVT3_N  in  1  CPU2 memory thermal event, active-low.
- FM_CPU2_SKTOCC_LVT3_N  in  1  CPU2 socket occupied, active-low.
- iBmcAck  in  1  BMC has logged the event; level, sampled in LOG.
- iPwrDownDone  in  1  Power sequencer reports the rails are off.
- iClrLatch  in  1  BMC clear of the latched record; single-cycle pulse or level.
- oBmcAlert_n  out  1  Thermal alert to the BMC, active-low; reset value 1.
- FM_THERMTRIP_DLY  out  1  Shutdown request to the power sequencer; reset value 0.
- oThermLatched  out  1  A qualified trip is recorded; reset value 0.
- oThermSrc  out  4  Captured sources: {mem2, mem1, cpu2, cpu1}; reset value 4'h0.
- oState  out  3  Encoded FSM state for debug; reset value IDLE.

## Operation

- All five pin inputs pass through 2-flop synchronizers.
- Masked event vector:
  - bit0 = ~cpu1_trip_n
  - bit1 = ~cpu2_trip_n & ~sktocc_n
  - bit2 = ~mem1_n
  - bit3 = ~mem2_n & ~sktocc_n
- anyEvt = OR of the masked event vector.
- State machine (one shared timer; the timer clears on every state entry):
  - IDLE: all outputs inactive. When iCpuPwrgdDly=1, go to ARM.
  - ARM: the timer counts. If pwrgd drops, go to IDLE. When the timer reaches T_ARM_2M-1, go to MONITOR.
  - MONITOR: if pwrgd drops, go to IDLE. If anyEvt=1, go to QUAL.
  - QUAL: each cycle, OR the masked vector into the capture register. If anyEvt=0, clear the capture register and go to MONITOR, so glitches do not accumulate across episodes. If pwrgd drops, go to IDLE. When anyEvt has been held for T_QUAL_2M consecutive cycles, go to LOG.
  - LOG: oBmcAlert_n=0 and oThermSrc frozen. Go to SHUTDOWN on iBmcAck=1 or on timer = T_BMC_2M-1, whichever comes first. If pwrgd drops, go to LATCHED directly, because the trip is already qualified.
  - SHUTDOWN: FM_THERMTRIP_DLY=1 and oBmcAlert_n=0. This state ignores pwrgd. On iPwrDownDone=1, go to LATCHED.
  - LATCHED: FM_THERMTRIP_DLY=0, oBmcAlert_n=0, oThermLatched=1, oThermSrc held. Go to IDLE only when iClrLatch=1 and iCpuPwrgdDly=0; clearing resets oThermSrc to 0. A clear while pwrgd=1 is ignored.
- iBmcAck or iClrLatch arriving in any state other than its own is ignored.
- Simultaneous events:
  - Pwrgd drop has priority over anyEvt in MONITOR and QUAL.
  - In LOG, iBmcAck and timeout arriving together give a single transition to SHUTDOWN.
- Timer: ceil(log2(max parameter+1)) bits. It saturates and never wraps.

## Timing

- All outputs are registered and driven from the state register; no combinational path runs from input to output.
- Pin assertion to oBmcAlert_n low is 2 (synchronizer) + 1 (MONITOR to QUAL) + T_QUAL_2M cycles. With defaults this is 203 cycles, 101.5 us.
- From LOG entry to FM_THERMTRIP_DLY high:
  - 1 cycle after iBmcAck is sampled high, or
  - T_BMC_2M cycles on timeout.
- iPwrDownDone high to FM_THERMTRIP_DLY low is 1 cycle.
- An asynchronous reset in any state forces all outputs to their reset values immediately. The latched record is lost on reset, by design.

## Structure

- Package thermtrip_pkg holds:
  - the state encoding: IDLE=0, ARM=1, MONITOR=2, QUAL=3, LOG=4, SHUTDOWN=5, LATCHED=6;
  - the source bit indices SRC_CPU1..SRC_MEM2;
  - the default timer constants.
- One sub-module: genCntr, instanced once as the shared state timer. The FSM drives its enable and clear.
- The synchronizers are inline flops.

## Test plan

- Pwrgd high, CPU1 trip held low for 300 cycles, iBmcAck high 50 cycles into LOG:
  - oBmcAlert_n falls at cycle 203;
  - FM_THERMTRIP_DLY rises 1 cycle after the ack;
  - oThermSrc=4'h1.
- CPU2 trip asserted with FM_CPU2_SKTOCC_LVT3_N=1: the FSM stays in MONITOR and the outputs never change.
- Mem1 event held for 150 cycles, released, then held for 150 more: QUAL is aborted twice, no alert, and the capture register ends at 0.
- Qualified mem2 trip with CPU2 present and no ack:
  - SHUTDOWN entered exactly 2000 cycles after LOG entry;
  - iPwrDownDone gives LATCHED with oThermSrc=4'h8.
- In LATCHED:
  - iClrLatch while pwrgd=1 is ignored;
  - after pwrgd falls, iClrLatch gives IDLE and oThermSrc=0.
- iRst_n asserted mid-SHUTDOWN: FM_THERMTRIP_DLY=0, oBmcAlert_n=1 and oThermLatched=0 in the same cycle.
